seq_muldiv_alu: RTL

//  Next-generation execute unit: width-parametrised ALU with the full RV32I op set
//  (single-cycle, registered) plus RV32M multiply/divide.
//  MUL/DIV/REM are computed iteratively, one bit per cycle.

---
 rtl/seq_muldiv_alu_pkg.sv | 67 ++++++
 rtl/seq_muldiv_alu_muldiv_iter.sv | 112 +++++++++++
 rtl/seq_muldiv_alu.sv | 137 +++++++++++++
 3 files changed

// File: rtl/seq_muldiv_alu_pkg.sv
// Shared types for the sequential mul/div ALU.
// Opcodes, FSM states and M-op decode helpers.
package seq_muldiv_alu_pkg;

  localparam int OP_W = 5;

  // Base ops keep 4-bit values; MSB set marks an RV32M op
  typedef enum logic [OP_W-1:0] {
    OP_ADD    = 5'h00,
    OP_SUB    = 5'h01,
    OP_SLL    = 5'h02,
    OP_SLT    = 5'h03,
    OP_SLTU   = 5'h04,
    OP_XOR    = 5'h05,
    OP_SRL    = 5'h06,
    OP_SRA    = 5'h07,
    OP_OR     = 5'h08,
    OP_AND    = 5'h09,
    OP_SUBU   = 5'h0A,
    OP_LUI    = 5'h0B,
    OP_AUIPC  = 5'h0C,
    OP_MUL    = 5'h10,
    OP_MULH   = 5'h11,
    OP_MULHSU = 5'h12,
    OP_MULHU  = 5'h13,
    OP_DIV    = 5'h14,
    OP_DIVU   = 5'h15,
    OP_REM    = 5'h16,
    OP_REMU   = 5'h17
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // sel_hi: high product half for MUL*, remainder for DIV*
  typedef struct packed {
    logic is_div;
    logic a_signed;
    logic b_signed;
    logic sel_hi;
  } md_ctrl_t;

  function automatic logic is_muldiv(input logic [OP_W-1:0] op);
    return op[OP_W-1];
  endfunction

  function automatic md_ctrl_t md_decode(input logic [OP_W-1:0] op);
    md_ctrl_t c;
    c = '0;
    case (op)
      OP_MUL:    c = '{is_div: 1'b0, a_signed: 1'b1, b_signed: 1'b1, sel_hi: 1'b0};
      OP_MULH:   c = '{is_div: 1'b0, a_signed: 1'b1, b_signed: 1'b1, sel_hi: 1'b1};
      OP_MULHSU: c = '{is_div: 1'b0, a_signed: 1'b1, b_signed: 1'b0, sel_hi: 1'b1};
      OP_MULHU:  c = '{is_div: 1'b0, a_signed: 1'b0, b_signed: 1'b0, sel_hi: 1'b1};
      OP_DIV:    c = '{is_div: 1'b1, a_signed: 1'b1, b_signed: 1'b1, sel_hi: 1'b0};
      OP_DIVU:   c = '{is_div: 1'b1, a_signed: 1'b0, b_signed: 1'b0, sel_hi: 1'b0};
      OP_REM:    c = '{is_div: 1'b1, a_signed: 1'b1, b_signed: 1'b1, sel_hi: 1'b1};
      OP_REMU:   c = '{is_div: 1'b1, a_signed: 1'b0, b_signed: 1'b0, sel_hi: 1'b1};
      default:   c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/seq_muldiv_alu_muldiv_iter.sv
// Iterative multiplier / restoring divider, one bit per step.
// Magnitudes in, sign fixed on the final step's value.
module seq_muldiv_alu_muldiv_iter
  import seq_muldiv_alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic            step_i,
  input  logic [OP_W-1:0] op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam int CW = $clog2(XLEN) + 1;
  localparam int W2 = 2 * XLEN;

  md_ctrl_t        ctrl;
  logic            sa;
  logic            sb;
  logic [XLEN-1:0] ma;
  logic [XLEN-1:0] mb;

  logic            is_div_q;
  logic            sel_hi_q;
  logic            neg_q;
  logic            div0_q;
  logic [XLEN-1:0] a_q;
  logic [XLEN-1:0] mc_q;
  logic [W2-1:0]   acc_q;
  logic [W2-1:0]   acc_d;
  logic [CW-1:0]   cnt_q;

  logic [XLEN:0]   sum;
  logic [XLEN:0]   trial;
  logic [XLEN:0]   diff;
  logic            q_bit;
  logic [W2-1:0]   prod;
  logic [XLEN-1:0] part;
  logic [XLEN-1:0] part_s;

  // Decode the op and take operand magnitudes at start
  always_comb begin
    ctrl = md_decode(op_i);
    sa   = ctrl.a_signed & a_i[XLEN-1];
    sb   = ctrl.b_signed & b_i[XLEN-1];
    ma   = sa ? -a_i : a_i;
    mb   = sb ? -b_i : b_i;
  end

  // One shift-add or one restoring-subtract step on the shared accumulator
  always_comb begin
    sum   = {1'b0, acc_q[W2-1:XLEN]}
          + (acc_q[0] ? {1'b0, mc_q} : '0);
    trial = acc_q[W2-1:XLEN-1];
    diff  = trial - {1'b0, mc_q};
    q_bit = ~diff[XLEN];
    if (is_div_q) begin
      acc_d = {q_bit ? diff[XLEN-1:0] : trial[XLEN-1:0],
               acc_q[XLEN-2:0], q_bit};
    end else begin
      acc_d = {sum, acc_q[XLEN-1:1]};
    end
  end

  // Sign fix-up and RISC-V divide-by-zero result on the post-step value
  always_comb begin
    prod   = neg_q ? -acc_d : acc_d;
    part   = sel_hi_q ? acc_d[W2-1:XLEN] : acc_d[XLEN-1:0];
    part_s = neg_q ? -part : part;
    if (!is_div_q) begin
      result_o = sel_hi_q ? prod[W2-1:XLEN] : prod[XLEN-1:0];
    end else if (div0_q) begin
      result_o = sel_hi_q ? a_q : '1;
    end else begin
      result_o = part_s;
    end
  end

  assign done_o = step_i & (cnt_q == CW'(XLEN - 1));

  // Operand latch at start, then one step per cycle while enabled
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      is_div_q <= 1'b0;
      sel_hi_q <= 1'b0;
      neg_q    <= 1'b0;
      div0_q   <= 1'b0;
      a_q      <= '0;
      mc_q     <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else if (start_i) begin
      is_div_q <= ctrl.is_div;
      sel_hi_q <= ctrl.sel_hi;
      neg_q    <= (ctrl.is_div & ctrl.sel_hi) ? sa : (sa ^ sb);
      div0_q   <= (b_i == '0);
      a_q      <= a_i;
      mc_q     <= ctrl.is_div ? mb : ma;
      acc_q    <= {{XLEN{1'b0}}, ctrl.is_div ? ma : mb};
      cnt_q    <= '0;
    end else if (step_i) begin
      acc_q <= acc_d;
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/seq_muldiv_alu.sv
// EX-stage ALU: single-cycle RV32I ops, iterative RV32M ops.
// valid/ready on both sides, flush kills the in-flight op.
module seq_muldiv_alu
  import seq_muldiv_alu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int OPW  = 5
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [OPW-1:0]  op,
  input  logic [XLEN-1:0] inA,
  input  logic [XLEN-1:0] inB,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out,
  output logic            zero,
  output logic            busy
);

  localparam int SHW = $clog2(XLEN);

  state_e          state_q;
  state_e          state_d;
  logic [XLEN-1:0] out_q;
  logic [XLEN-1:0] out_d;
  logic            zero_q;
  logic            zero_d;

  logic            accept;
  logic            md_start;
  logic            md_done;
  logic [XLEN-1:0] md_res;
  logic [XLEN-1:0] alu_res;
  logic [SHW-1:0]  shamt;
  logic signed [XLEN-1:0] lui_v;

  assign in_ready  = (state_q == ST_IDLE)
                   | ((state_q == ST_DONE) & out_ready);
  assign accept    = in_valid & in_ready & ~flush;
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q == ST_CALC);
  assign out       = out_q;
  assign zero      = zero_q;

  assign shamt = inB[SHW-1:0];
  assign lui_v = $signed({inB[31:12], 12'b0});

  // Combinational base ALU
  always_comb begin
    alu_res = '0;
    unique case (op)
      OP_ADD:   alu_res = inA + inB;
      OP_SUB:   alu_res = inA - inB;
      OP_SUBU:  alu_res = inA - inB;
      OP_SLL:   alu_res = inA << shamt;
      OP_SRL:   alu_res = inA >> shamt;
      OP_SRA:   alu_res = $signed(inA) >>> shamt;
      OP_SLT:   alu_res = {{(XLEN-1){1'b0}}, $signed(inA) < $signed(inB)};
      OP_SLTU:  alu_res = {{(XLEN-1){1'b0}}, inA < inB};
      OP_XOR:   alu_res = inA ^ inB;
      OP_OR:    alu_res = inA | inB;
      OP_AND:   alu_res = inA & inB;
      OP_LUI:   alu_res = lui_v;
      OP_AUIPC: alu_res = inA + lui_v;
      default:  alu_res = '0;
    endcase
  end

  seq_muldiv_alu_muldiv_iter #(
    .XLEN (XLEN)
  ) u_md (
    .clk_i    (clock),
    .rst_i    (reset),
    .start_i  (md_start),
    .step_i   (busy),
    .op_i     (op),
    .a_i      (inA),
    .b_i      (inB),
    .done_o   (md_done),
    .result_o (md_res)
  );

  // Next state, result capture and start pulse; flush overrides all
  always_comb begin
    state_d  = state_q;
    out_d    = out_q;
    zero_d   = zero_q;
    md_start = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accept) begin
          if (is_muldiv(op)) begin
            state_d  = ST_CALC;
            md_start = 1'b1;
          end else begin
            state_d = ST_DONE;
            out_d   = alu_res;
            zero_d  = (alu_res == '0);
          end
        end else if ((state_q == ST_DONE) && out_ready) begin
          state_d = ST_IDLE;
        end
      end
      ST_CALC: begin
        if (md_done) begin
          state_d = ST_DONE;
          out_d   = md_res;
          zero_d  = (md_res == '0);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (flush) begin
      state_d = ST_IDLE;
      out_d   = out_q;
      zero_d  = zero_q;
    end
  end

  // State and output register; reset also clears the result
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      out_q   <= '0;
      zero_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      zero_q  <= zero_d;
    end
  end

endmodule
